tick_gen_multi: RTL and testbench

Parametrised multi-channel tick generator. Each channel is a down-counter with a runtime-programmable period, a periodic/one-shot mode and start/stop control. Each channel emits a single-cycle pulse each time its counter expires. It supplies timebases to PWM, breathing-LED and debounce logic on the sys_clk domain, replacing fixed single-period tick counters.

---
 rtl/tick_gen_multi.sv | 84 ++++++++
 tb/tb_tick_gen_multi.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/tick_gen_multi.sv
// Multi-channel down-counter tick generator; TICK_GEN_CASCADE_EN chains channel k to tick[k-1] as a prescaler.
// Latency: tick registered on the (P+1)th enabled edge after a load; config writes land on the next edge.
// Backpressure: none; en low freezes every counter, ch_stop halts a single channel.
module tick_gen_multi #(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 32,
    parameter int DEF_PERIOD = 100000,
    parameter int DEF_RUN    = 1,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              en,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic              cfg_mode,
    input  logic              cfg_start,
    input  logic [NUM_CH-1:0] ch_stop,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] running
);

    logic [CNT_W-1:0]  period_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_q    [NUM_CH];
    logic [NUM_CH-1:0] mode_q;
    logic [NUM_CH-1:0] run_q;
    logic [NUM_CH-1:0] tick_q;
    logic [NUM_CH-1:0] adv;

    // Per-channel advance qualifier; cascading gates channel k on the previous channel's pulse
    always_comb begin
        adv = '1;
`ifdef TICK_GEN_CASCADE_EN
        for (int k = 1; k < NUM_CH; k++) begin
            adv[k] = tick_q[k-1];
        end
`endif
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                period_q[k] <= CNT_W'(DEF_PERIOD);
                cnt_q[k]    <= CNT_W'(DEF_PERIOD);
            end
            mode_q <= '0;
            run_q  <= {NUM_CH{DEF_RUN != 0}};
            tick_q <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (cfg_we && (32'(cfg_ch) == k)) begin
                    // Write beats same-cycle expiry; a stop still vetoes the start
                    period_q[k] <= cfg_period;
                    cnt_q[k]    <= cfg_period;
                    mode_q[k]   <= cfg_mode;
                    run_q[k]    <= cfg_start && !ch_stop[k];
                    tick_q[k]   <= 1'b0;
                end else if (ch_stop[k]) begin
                    run_q[k]  <= 1'b0;
                    tick_q[k] <= 1'b0;
                end else if (en && run_q[k] && adv[k]) begin
                    if (cnt_q[k] != '0) begin
                        cnt_q[k]  <= cnt_q[k] - CNT_W'(1);
                        tick_q[k] <= 1'b0;
                    end else begin
                        tick_q[k] <= 1'b1;
                        if (mode_q[k]) begin
                            run_q[k] <= 1'b0;
                        end else begin
                            cnt_q[k] <= period_q[k];
                        end
                    end
                end else begin
                    tick_q[k] <= 1'b0;
                end
            end
        end
    end

    assign tick    = tick_q;
    assign running = run_q;

endmodule

// File: tb/tb_tick_gen_multi.sv
// Bench for tick_gen_multi: a 4-channel and a 3-channel instance on a shared config bus,
// compared each cycle against an edges-remaining reference model.
module tb_tick_gen_multi;

    localparam int CW = 16;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          en;
    logic          cfg_we;
    logic [1:0]    cfg_ch;
    logic [CW-1:0] cfg_period;
    logic          cfg_mode;
    logic          cfg_start;
    logic [3:0]    ch_stop;
    logic [3:0]    tick_a, running_a;
    logic [2:0]    tick_b, running_b;

    int total = 0;
    int bad   = 0;

    always #5 sys_clk = ~sys_clk;

    tick_gen_multi #(.NUM_CH(4), .CNT_W(CW), .DEF_PERIOD(3), .DEF_RUN(1)) dut_a (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_period(cfg_period), .cfg_mode(cfg_mode), .cfg_start(cfg_start),
        .ch_stop(ch_stop), .tick(tick_a), .running(running_a)
    );

    // Three channels with a 2-bit cfg_ch leaves index 3 as an out-of-range write target
    tick_gen_multi #(.NUM_CH(3), .CNT_W(CW), .DEF_PERIOD(3), .DEF_RUN(0)) dut_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_period(cfg_period), .cfg_mode(cfg_mode), .cfg_start(cfg_start),
        .ch_stop(ch_stop[2:0]), .tick(tick_b), .running(running_b)
    );

    // Reference state: edges remaining until the next expiry, not a counter image
    logic [3:0] m_tick [2];
    logic [3:0] m_run  [2];
    longint     m_rem  [2][4];
    longint     m_per  [2][4];
    bit         m_mode [2][4];

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            int n = (d == 0) ? 4 : 3;
            logic [3:0] prev = m_tick[d];
            for (int k = 0; k < n; k++) begin
                bit adv = 1'b1;
`ifdef TICK_GEN_CASCADE_EN
                if (k > 0) adv = prev[k-1];
`endif
                if (sys_rst) begin
                    m_per[d][k]  = 3;
                    m_rem[d][k]  = 4;
                    m_mode[d][k] = 1'b0;
                    m_run[d][k]  = (d == 0);
                    m_tick[d][k] = 1'b0;
                end else if (cfg_we && int'(cfg_ch) == k) begin
                    m_per[d][k]  = longint'(cfg_period);
                    m_rem[d][k]  = longint'(cfg_period) + 1;
                    m_mode[d][k] = cfg_mode;
                    m_run[d][k]  = cfg_start && !ch_stop[k];
                    m_tick[d][k] = 1'b0;
                end else if (ch_stop[k]) begin
                    m_run[d][k]  = 1'b0;
                    m_tick[d][k] = 1'b0;
                end else if (en && m_run[d][k] && adv) begin
                    m_rem[d][k]  = m_rem[d][k] - 1;
                    m_tick[d][k] = (m_rem[d][k] == 0);
                    if (m_rem[d][k] == 0) begin
                        if (m_mode[d][k]) begin
                            m_run[d][k] = 1'b0;
                            m_rem[d][k] = 1;
                        end else begin
                            m_rem[d][k] = m_per[d][k] + 1;
                        end
                    end
                end else begin
                    m_tick[d][k] = 1'b0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge sys_clk);
        #1;
        chk("tick_a",    32'(tick_a),    32'(m_tick[0]));
        chk("running_a", 32'(running_a), 32'(m_run[0]));
        chk("tick_b",    32'(tick_b),    32'(m_tick[1][2:0]));
        chk("running_b", 32'(running_b), 32'(m_run[1][2:0]));
    endtask

    task automatic write(input int ch, input int per, input bit mode, input bit start);
        cfg_we     = 1'b1;
        cfg_ch     = 2'(ch);
        cfg_period = CW'(per);
        cfg_mode   = mode;
        cfg_start  = start;
        step();
        cfg_we     = 1'b0;
    endtask

    initial begin
        int         cnt;
        logic [2:0] rb;
        for (int d = 0; d < 2; d++) begin
            m_tick[d] = '0;
            m_run[d]  = '0;
        end
        sys_rst = 1'b1; en = 1'b1; cfg_we = 1'b0; cfg_ch = '0;
        cfg_period = '0; cfg_mode = 1'b0; cfg_start = 1'b0; ch_stop = '0;

        step();
        step();
        chk("reset_running_a", 32'(running_a), 32'h0000_000f);
        chk("reset_running_b", 32'(running_b), 32'h0000_0000);
        chk("reset_tick_a",    32'(tick_a),    32'h0000_0000);
        sys_rst = 1'b0;

        // Default period 3: ch0 pulses on enabled edges 4, 8 and 12 after release
        for (int e = 1; e <= 12; e++) begin
            step();
            chk("rst_rel_tick0", 32'(tick_a[0]), 32'((e % 4) == 0));
        end

        write(2, 0, 1'b0, 1'b1);
        repeat (6) step();

        write(1, 5, 1'b1, 1'b1);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (tick_a[1]) cnt++;
        end
        chk("oneshot_count",   32'(cnt),          32'd1);
        chk("oneshot_stopped", 32'(running_a[1]), 32'd0);
        write(1, 5, 1'b1, 1'b1);
        chk("oneshot_restart", 32'(running_a[1]), 32'd1);
        repeat (8) step();

        write(0, 3, 1'b0, 1'b1);
        repeat (2) step();
        en = 1'b0;
        repeat (10) step();
        chk("en_low_no_tick", 32'(tick_a), 32'd0);
        en = 1'b1;
        repeat (10) step();

        ch_stop = 4'b1000;
        write(3, 7, 1'b0, 1'b1);
        chk("stop_beats_start", 32'(running_a[3]), 32'd0);
        ch_stop = '0;
        step();
        write(3, 7, 1'b0, 1'b1);
        repeat (10) step();

        rb = m_run[1][2:0];
        write(3, 0, 1'b0, 1'b1);
        chk("oob_write_ignored", 32'(running_b), 32'(rb));
        repeat (3) step();

        sys_rst = 1'b1;
        step();
        chk("midrst_tick",    32'(tick_a),    32'd0);
        chk("midrst_running", 32'(running_a), 32'h0000_000f);
        sys_rst = 1'b0;

`ifdef TICK_GEN_CASCADE_EN
        write(0, 1, 1'b0, 1'b1);
        write(1, 2, 1'b0, 1'b1);
        repeat (24) step();
`endif

        for (int i = 0; i < 500; i++) begin
            sys_rst    = ($urandom_range(0, 99) == 0);
            en         = ($urandom_range(0, 5) != 0);
            cfg_we     = ($urandom_range(0, 7) == 0);
            cfg_ch     = 2'($urandom_range(0, 3));
            cfg_period = CW'($urandom_range(0, 9));
            cfg_mode   = ($urandom_range(0, 3) == 0);
            cfg_start  = ($urandom_range(0, 4) != 0);
            ch_stop    = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
